shift_ctrl: RTL and testbench

- Sequencer that owns the processor's single 8-bit right barrel shifter and turns it into a full shift/rotate unit.
- Supported operations: logical left (sll), logical right (srl), arithmetic right (sra) and rotate right (ror).
- Left shifts use bit-reversal around the shifter. Rotates take two shifter passes whose results are ORed.
- Sits between the instruction decode/ALU-select logic and the shared shifter instance. Uses a start/busy/done handshake.

---
 rtl/shift_ctrl_pkg.sv | 37 +++
 rtl/shift_ctrl_bit_rev8.sv | 13 +
 rtl/shift_ctrl.sv | 150 +++++++++++++++
 tb/tb_shift_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift/rotate sequencer: operation codes, FSM states,
// widths and the effective-amount helper.
package shift_ctrl_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned SH_AMT_W = 4;
    localparam int unsigned OP_W     = 2;
    localparam int unsigned ST_W     = 2;
    localparam int unsigned ROT_W    = 3;

    localparam logic [OP_W-1:0] OP_SLL = 2'b00;
    localparam logic [OP_W-1:0] OP_SRL = 2'b01;
    localparam logic [OP_W-1:0] OP_SRA = 2'b10;
    localparam logic [OP_W-1:0] OP_ROR = 2'b11;

    localparam logic [ST_W-1:0] IDLE    = 2'd0;
    localparam logic [ST_W-1:0] PASS1   = 2'd1;
    localparam logic [ST_W-1:0] PASS2   = 2'd2;
    localparam logic [ST_W-1:0] DONE_ST = 2'd3;

    localparam logic [SH_AMT_W-1:0] SH_FULL = 4'd8;

    // First-pass shifter amount: shifts saturate to a full fill, rotates wrap mod 8.
    function automatic logic [SH_AMT_W-1:0] eff_amount(input logic [OP_W-1:0]   op,
                                                       input logic [DATA_W-1:0] amount);
        logic [SH_AMT_W-1:0] amt;
        if (op == OP_ROR) begin
            amt = SH_AMT_W'(amount[ROT_W-1:0]);
        end else if (amount >= DATA_W'(SH_FULL)) begin
            amt = SH_FULL;
        end else begin
            amt = amount[SH_AMT_W-1:0];
        end
        return amt;
    endfunction

endpackage

// File: rtl/shift_ctrl_bit_rev8.sv
// Combinational 8-bit bit reversal used around the right-only shifter.
module bit_rev8
    import shift_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout_c
);

    for (genvar i = 0; i < DATA_W; i++) begin : g_rev
        assign dout_c[i] = din[DATA_W-1-i];
    end

endmodule

// File: rtl/shift_ctrl.sv
// Sequencer that drives a shared combinational right barrel shifter to implement
// sll/srl/sra/ror. SH_* drive is registered so it is stable for the whole pass.
module shift_ctrl
    import shift_ctrl_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                START,
    input  logic [OP_W-1:0]     OP,
    input  logic [DATA_W-1:0]   DATA_IN,
    input  logic [DATA_W-1:0]   AMOUNT,
    output logic                BUSY,
    output logic                DONE,
    output logic [DATA_W-1:0]   RESULT,
    output logic [DATA_W-1:0]   SH_INDATA,
    output logic [SH_AMT_W-1:0] SH_AMOUNT,
    output logic                SH_S,
    input  logic [DATA_W-1:0]   SH_OUTDATA
);

    logic [ST_W-1:0]     state_q,     state_d;
    logic [OP_W-1:0]     op_q,        op_d;
    logic [DATA_W-1:0]   data_q,      data_d;
    logic [ROT_W-1:0]    n_q,         n_d;
    logic                rev_q,       rev_d;
    logic [DATA_W-1:0]   result_q,    result_d;
    logic                done_q,      done_d;
    logic                busy_q,      busy_d;
    logic [DATA_W-1:0]   sh_indata_q, sh_indata_d;
    logic [SH_AMT_W-1:0] sh_amount_q, sh_amount_d;
    logic                sh_s_q,      sh_s_d;

    logic [DATA_W-1:0]   rev_src_c;
    logic [DATA_W-1:0]   rev_in_c;
    logic [DATA_W-1:0]   rev_out_c;
    logic [DATA_W-1:0]   corrected_c;

    // Input-side reversal sees the live operand while idle, the captured one afterwards.
    assign rev_src_c = (state_q == IDLE) ? DATA_IN : data_q;

    bit_rev8 u_rev_in (
        .din    (rev_src_c),
        .dout_c (rev_in_c)
    );

    bit_rev8 u_rev_out (
        .din    (SH_OUTDATA),
        .dout_c (rev_out_c)
    );

    assign corrected_c = rev_q ? rev_out_c : SH_OUTDATA;

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        n_d         = n_q;
        rev_d       = rev_q;
        result_d    = result_q;
        done_d      = 1'b0;
        sh_indata_d = '0;
        sh_amount_d = '0;
        sh_s_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d     = PASS1;
                    op_d        = OP;
                    data_d      = DATA_IN;
                    n_d         = AMOUNT[ROT_W-1:0];
                    sh_amount_d = eff_amount(OP, AMOUNT);
                    rev_d       = 1'b0;
                    case (OP)
                        OP_SLL: begin
                            sh_indata_d = rev_in_c;
                            rev_d       = 1'b1;
                        end
                        OP_SRA: begin
                            sh_indata_d = DATA_IN;
                            sh_s_d      = DATA_IN[DATA_W-1];
                        end
                        default: sh_indata_d = DATA_IN;
                    endcase
                end
            end
            PASS1: begin
                result_d = corrected_c;
                if (op_q == OP_ROR && n_q != '0) begin
                    // Second rotate pass: logical left by 8-n of the original operand.
                    state_d     = PASS2;
                    sh_indata_d = rev_in_c;
                    sh_amount_d = SH_FULL - SH_AMT_W'(n_q);
                    rev_d       = 1'b1;
                end else begin
                    state_d = DONE_ST;
                    done_d  = 1'b1;
                    rev_d   = 1'b0;
                end
            end
            PASS2: begin
                result_d = result_q | corrected_c;
                state_d  = DONE_ST;
                done_d   = 1'b1;
                rev_d    = 1'b0;
            end
            DONE_ST: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            op_q        <= '0;
            data_q      <= '0;
            n_q         <= '0;
            rev_q       <= 1'b0;
            result_q    <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            sh_indata_q <= '0;
            sh_amount_q <= '0;
            sh_s_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            n_q         <= n_d;
            rev_q       <= rev_d;
            result_q    <= result_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            sh_indata_q <= sh_indata_d;
            sh_amount_q <= sh_amount_d;
            sh_s_q      <= sh_s_d;
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign RESULT    = result_q;
    assign SH_INDATA = sh_indata_q;
    assign SH_AMOUNT = sh_amount_q;
    assign SH_S      = sh_s_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Testbench for shift_ctrl with a behavioural right barrel shifter and a result scoreboard.
module tb_shift_ctrl;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       START = 1'b0;
    logic [1:0] OP = 2'b00;
    logic [7:0] DATA_IN = 8'h00;
    logic [7:0] AMOUNT = 8'h00;
    logic       BUSY;
    logic       DONE;
    logic [7:0] RESULT;
    logic [7:0] SH_INDATA;
    logic [3:0] SH_AMOUNT;
    logic       SH_S;
    logic [7:0] SH_OUTDATA;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [7:0] exp_q[$];
    int         lat_q[$];

    shift_ctrl dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .START      (START),
        .OP         (OP),
        .DATA_IN    (DATA_IN),
        .AMOUNT     (AMOUNT),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .RESULT     (RESULT),
        .SH_INDATA  (SH_INDATA),
        .SH_AMOUNT  (SH_AMOUNT),
        .SH_S       (SH_S),
        .SH_OUTDATA (SH_OUTDATA)
    );

    always #5 CLK = ~CLK;

    // Right barrel shifter with fill bit; amounts of 8 or more fill completely.
    always_comb begin
        SH_OUTDATA = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (i + int'(SH_AMOUNT) < 8) SH_OUTDATA[i] = SH_INDATA[i + int'(SH_AMOUNT)];
            else                         SH_OUTDATA[i] = SH_S;
        end
    end

    function automatic logic [7:0] ref_op(input logic [1:0] op, input logic [7:0] d, input logic [7:0] a);
        logic [15:0] dd;
        logic [7:0]  r;
        case (op)
            2'b00:   r = (a >= 8) ? 8'h00 : 8'(d << a);
            2'b01:   r = (a >= 8) ? 8'h00 : 8'(d >> a);
            2'b10:   r = (a >= 8) ? {8{d[7]}} : 8'($signed(d) >>> a);
            default: begin
                dd = {d, d} >> a[2:0];
                r  = dd[7:0];
            end
        endcase
        return r;
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
        return r;
    endfunction

    // Issues one operation starting at the current negedge and returns at the idle negedge after DONE.
    task automatic do_op(input logic [1:0] op, input logic [7:0] d, input logic [7:0] a, input string tag);
        logic [7:0] e_r, e_in;
        logic [3:0] e_amt;
        logic       e_s;
        int         e_l, lat;
        exp_q.push_back(ref_op(op, d, a));
        lat_q.push_back((op == 2'b11 && a[2:0] != 3'd0) ? 3 : 2);
        e_in  = (op == 2'b00) ? rev8(d) : d;
        e_amt = (op == 2'b11) ? {1'b0, a[2:0]} : ((a >= 8) ? 4'd8 : a[3:0]);
        e_s   = (op == 2'b10) ? d[7] : 1'b0;
        START = 1'b1; OP = op; DATA_IN = d; AMOUNT = a;
        @(negedge CLK);
        START = 1'b0;
        chk_cnt++;
        if (BUSY === 1'b1 && SH_INDATA === e_in && SH_AMOUNT === e_amt && SH_S === e_s) pass_cnt++;
        else $display("FAIL %s pass1_drive: busy=%b in=%h amt=%0d s=%b, required busy=1 in=%h amt=%0d s=%b",
                      tag, BUSY, SH_INDATA, SH_AMOUNT, SH_S, e_in, e_amt, e_s);
        lat = 1;
        while (DONE !== 1'b1 && lat < 8) begin
            @(negedge CLK);
            lat++;
        end
        e_r = exp_q.pop_front();
        e_l = lat_q.pop_front();
        chk_cnt++;
        if (DONE === 1'b1 && lat == e_l && BUSY === 1'b1) pass_cnt++;
        else $display("FAIL %s latency: done=%b busy=%b cycle=%0d, required done=1 busy=1 cycle=%0d",
                      tag, DONE, BUSY, lat, e_l);
        chk_cnt++;
        if (RESULT === e_r) pass_cnt++;
        else $display("FAIL %s result: got %h, required %h", tag, RESULT, e_r);
        @(negedge CLK);
        chk_cnt++;
        if (DONE === 1'b0 && BUSY === 1'b0 && RESULT === e_r && SH_INDATA === 8'h00 && SH_AMOUNT === 4'd0 && SH_S === 1'b0)
            pass_cnt++;
        else $display("FAIL %s idle_after: done=%b busy=%b result=%h sh=%h/%0d/%b, required 0 0 %h 00/0/0",
                      tag, DONE, BUSY, RESULT, SH_INDATA, SH_AMOUNT, SH_S, e_r);
    endtask

    task automatic test_reset();
        #3;
        chk_cnt++;
        if (BUSY === 1'b0 && DONE === 1'b0 && RESULT === 8'h00 && SH_INDATA === 8'h00 && SH_AMOUNT === 4'd0 && SH_S === 1'b0)
            pass_cnt++;
        else $display("FAIL reset_state: busy=%b done=%b result=%h sh=%h/%0d/%b, required all zero",
                      BUSY, DONE, RESULT, SH_INDATA, SH_AMOUNT, SH_S);
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_plan_ops();
        do_op(2'b01, 8'hB4, 8'd2,  "srl_b4_2");
        do_op(2'b10, 8'hB4, 8'd3,  "sra_b4_3");
        do_op(2'b10, 8'h80, 8'd9,  "sra_80_9");
        do_op(2'b00, 8'h0F, 8'd3,  "sll_0f_3");
        do_op(2'b00, 8'hFF, 8'h20, "sll_ff_20");
        do_op(2'b11, 8'h81, 8'd1,  "ror_81_1");
        do_op(2'b11, 8'h12, 8'd12, "ror_12_12");
        do_op(2'b11, 8'h81, 8'd8,  "ror_81_8");
        do_op(2'b01, 8'hA5, 8'd8,  "srl_a5_8");
        do_op(2'b10, 8'h7F, 8'd7,  "sra_7f_7");
    endtask

    task automatic test_start_ignored();
        int extra_done;
        exp_q.push_back(8'h2D);
        START = 1'b1; OP = 2'b01; DATA_IN = 8'hB4; AMOUNT = 8'd2;
        @(negedge CLK);
        OP = 2'b00; DATA_IN = 8'hFF; AMOUNT = 8'd1;
        @(negedge CLK);
        chk_cnt++;
        if (DONE === 1'b1 && RESULT === exp_q[0]) pass_cnt++;
        else $display("FAIL ignore_done: done=%b result=%h, required done=1 result=%h", DONE, RESULT, exp_q[0]);
        @(negedge CLK);
        START = 1'b0;
        chk_cnt++;
        if (DONE === 1'b0 && BUSY === 1'b0) pass_cnt++;
        else $display("FAIL ignore_idle: done=%b busy=%b, required 0 0", DONE, BUSY);
        extra_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1 || BUSY === 1'b1) extra_done++;
        end
        chk_cnt++;
        if (extra_done == 0 && RESULT === exp_q[0]) pass_cnt++;
        else $display("FAIL ignore_single: activity=%0d result=%h, required 0 and %h", extra_done, RESULT, exp_q[0]);
        void'(exp_q.pop_front());
    endtask

    task automatic test_back_to_back();
        do_op(2'b01, 8'hC3, 8'd1, "b2b_first");
        do_op(2'b11, 8'h81, 8'd8, "b2b_second");
        do_op(2'b11, 8'h3C, 8'd5, "b2b_third");
    endtask

    task automatic test_reset_mid_op();
        int seen;
        START = 1'b1; OP = 2'b11; DATA_IN = 8'h81; AMOUNT = 8'd1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        chk_cnt++;
        if (BUSY === 1'b1 && RESULT === 8'h40 && SH_INDATA === 8'h81 && SH_AMOUNT === 4'd7) pass_cnt++;
        else $display("FAIL pass2_state: busy=%b result=%h in=%h amt=%0d, required 1 40 81 7",
                      BUSY, RESULT, SH_INDATA, SH_AMOUNT);
        #2 RESET_N = 1'b0;
        #1;
        chk_cnt++;
        if (BUSY === 1'b0 && RESULT === 8'h00 && DONE === 1'b0 && SH_AMOUNT === 4'd0) pass_cnt++;
        else $display("FAIL async_reset: busy=%b result=%h done=%b amt=%0d, required 0 00 0 0",
                      BUSY, RESULT, DONE, SH_AMOUNT);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) seen++;
        end
        RESET_N = 1'b1;
        @(negedge CLK);
        if (DONE === 1'b1) seen++;
        chk_cnt++;
        if (seen == 0 && BUSY === 1'b0) pass_cnt++;
        else $display("FAIL reset_no_done: dones=%0d busy=%b, required 0 0", seen, BUSY);
        do_op(2'b01, 8'h10, 8'd4, "after_reset");
    endtask

    task automatic test_random();
        for (int k = 0; k < 16; k++) begin
            do_op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom_range(0, 20)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_plan_ops();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
